// File: rtl/dram_responder.sv
// dram_responder: target side of the DLX data-memory handshake.
// Latches a request in IDLE, waits WAIT_CYCLES states in BUSY, then pulses
// ready for one DONE cycle. Backing store is a word-addressed big-endian array.
// The array has no reset and powers up undefined; simulation environments
// preload it by writing through the port.
module dram_responder #(
   parameter int WORD_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dram_enable_cu,
   input  logic              dram_r_nw_cu,
   input  logic [ADDR_W-1:0] dram_addr,
   input  logic [WORD_W-1:0] dram_data_in,
   output logic [WORD_W-1:0] dram_data_out,
   output logic              dram_ready_cu,
   output logic              dram_addr_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state, next_state;
   logic [3:0]          cnt;
   logic                r_nw_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [WORD_W-1:0]   data_q;
   logic [WORD_W-1:0]   data_out_q;
   logic [WORD_W-1:0]   mem [0:(2**DEPTH_LOG2)-1];

   // With WAIT_CYCLES = 0 the read happens on the sampling edge itself, so
   // the live port values stand in for the not-yet-latched ones.
   logic                sel_r_nw;
   logic [ADDR_W-1:0]   sel_addr;

   // Misaligned or beyond the array: such accesses still complete, but
   // never touch the array.
   function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
      return (a[1:0] != 2'b00) || (|a[ADDR_W-1:DEPTH_LOG2+2]);
   endfunction

   // Pick live or latched request fields depending on where we are.
   always_comb begin
      sel_r_nw = r_nw_q;
      sel_addr = addr_q;
      if (state == IDLE) begin
         sel_r_nw = dram_r_nw_cu;
         sel_addr = dram_addr;
      end
   end

   // Next-state logic; dropping enable in BUSY aborts the request.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (dram_enable_cu) next_state = (WAIT_CYCLES == 0) ? DONE : BUSY;
         BUSY: begin
            if (!dram_enable_cu)   next_state = IDLE;
            else if (cnt == 4'd1)  next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register, request latch, wait counter and registered read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         r_nw_q     <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         data_out_q <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && dram_enable_cu) begin
            cnt    <= 4'(WAIT_CYCLES);
            r_nw_q <= dram_r_nw_cu;
            addr_q <= dram_addr;
            data_q <= dram_data_in;
         end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
         end
         if (next_state == DONE && sel_r_nw && !addr_bad(sel_addr))
            data_out_q <= mem[sel_addr[DEPTH_LOG2+1:2]];
         else
            data_out_q <= '0;
      end
   end

   // Store commits on the edge leaving DONE; an async reset in DONE has
   // already moved state to IDLE, so no commit follows.
   always_ff @(posedge clk) begin
      if (state == DONE && !r_nw_q && !addr_bad(addr_q))
         mem[addr_q[DEPTH_LOG2+1:2]] <= data_q;
   end

   assign dram_ready_cu = (state == DONE);
   assign dram_addr_err = (state == DONE) && addr_bad(addr_q);
   assign dram_data_out = data_out_q;

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: a WAIT_CYCLES=2 instance carries most
// of the traffic, a WAIT_CYCLES=0 instance covers the back-to-back case.
module tb_dram_responder;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        en, rnw, rdy, err;
   logic [31:0] addr, din, dout;
   logic        en0, rnw0, rdy0, err0;
   logic [31:0] addr0, din0, dout0;

   int checks = 0;
   int errors = 0;

   dram_responder #(.WORD_W(32), .ADDR_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .rst(rst), .dram_enable_cu(en), .dram_r_nw_cu(rnw),
      .dram_addr(addr), .dram_data_in(din), .dram_data_out(dout),
      .dram_ready_cu(rdy), .dram_addr_err(err));

   dram_responder #(.WORD_W(32), .ADDR_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .dram_enable_cu(en0), .dram_r_nw_cu(rnw0),
      .dram_addr(addr0), .dram_data_in(din0), .dram_data_out(dout0),
      .dram_ready_cu(rdy0), .dram_addr_err(err0));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   // One access on u_dut; lat counts edges from the sampling cycle to the
   // ready cycle (-1 if ready never came). Returns in the following IDLE cycle.
   task automatic acc(input logic r, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] q, output logic e);
      en = 1'b1; rnw = r; addr = a; din = d;
      lat = -1; q = '0; e = 1'b0;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         @(posedge clk); #1;
         if (rdy) begin lat = n; q = dout; e = err; en = 1'b0; end
      end
      en = 1'b0;
      @(posedge clk); #1;
   endtask

   int          lat, pulses;
   logic [31:0] q;
   logic        e;
   logic [4:0]  pat;
   logic [31:0] q0;

   initial begin
      rst = 1'b1;
      en = 0; rnw = 0; addr = 0; din = 0;
      en0 = 0; rnw0 = 0; addr0 = 0; din0 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(rdy), 32'd0);
      chk("rst_err",   32'(err), 32'd0);
      chk("rst_dout",  dout, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Seed locations the abort and reset cases read back later.
      acc(1'b0, 32'h20, 32'h11112222, lat, q, e);
      acc(1'b0, 32'h24, 32'h33334444, lat, q, e);

      // Write then read, latency WAIT_CYCLES+1.
      acc(1'b0, 32'h10, 32'hDEADBEEF, lat, q, e);
      chk("wr10_lat",  32'(lat), 32'd3);
      chk("wr10_err",  32'(e), 32'd0);
      chk("wr10_dout", q, 32'd0);
      acc(1'b1, 32'h10, 32'h0, lat, q, e);
      chk("rd10_lat",  32'(lat), 32'd3);
      chk("rd10_data", q, 32'hDEADBEEF);
      chk("rd10_err",  32'(e), 32'd0);

      // Misaligned write: error, no commit.
      acc(1'b0, 32'h13, 32'h12345678, lat, q, e);
      chk("wr13_lat", 32'(lat), 32'd3);
      chk("wr13_err", 32'(e), 32'd1);
      acc(1'b1, 32'h10, 32'h0, lat, q, e);
      chk("rd10_after_mis", q, 32'hDEADBEEF);

      // Out of range read.
      acc(1'b1, 32'h400, 32'h0, lat, q, e);
      chk("rd400_lat",  32'(lat), 32'd3);
      chk("rd400_err",  32'(e), 32'd1);
      chk("rd400_data", q, 32'd0);

      // Last in-range word.
      acc(1'b0, 32'h3FC, 32'hA5A5C3C3, lat, q, e);
      chk("wr3fc_err", 32'(e), 32'd0);
      acc(1'b1, 32'h3FC, 32'h0, lat, q, e);
      chk("rd3fc_data", q, 32'hA5A5C3C3);
      chk("rd3fc_err",  32'(e), 32'd0);

      // Abort: enable dropped after one BUSY cycle.
      en = 1'b1; rnw = 1'b0; addr = 32'h20; din = 32'hCAFEF00D;
      @(posedge clk); #1;
      en = 1'b0;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         if (rdy) pulses++;
         @(posedge clk); #1;
      end
      chk("abort_pulses", 32'(pulses), 32'd0);
      acc(1'b1, 32'h20, 32'h0, lat, q, e);
      chk("abort_rd20", q, 32'h11112222);
      chk("abort_lat",  32'(lat), 32'd3);

      // Reset during DONE of a write.
      en = 1'b1; rnw = 1'b0; addr = 32'h24; din = 32'h55AA55AA;
      lat = -1;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         @(posedge clk); #1;
         if (rdy) lat = n;
      end
      chk("rstdone_lat", 32'(lat), 32'd3);
      rst = 1'b1;
      #1;
      chk("rstdone_ready", 32'(rdy), 32'd0);
      chk("rstdone_err",   32'(err), 32'd0);
      en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      acc(1'b1, 32'h24, 32'h0, lat, q, e);
      chk("rstdone_rd24", q, 32'h33334444);

      // WAIT_CYCLES=0: seed word 0, then hold read enable for 4 cycles.
      en0 = 1'b1; rnw0 = 1'b0; addr0 = 32'h0; din0 = 32'h0BADF00D;
      @(posedge clk); #1;
      chk("w0_wr_ready", 32'(rdy0), 32'd1);
      en0 = 1'b0;
      @(posedge clk); #1;
      en0 = 1'b1; rnw0 = 1'b1; addr0 = 32'h0;
      pat = '0; q0 = '0;
      for (int c = 0; c < 5; c++) begin
         pat[c] = rdy0;
         if (c == 1) q0 = dout0;
         if (c == 3) en0 = 1'b0;
         @(posedge clk); #1;
      end
      chk("w0_ready_pattern", 32'(pat), 32'b01010);
      chk("w0_rd_data", q0, 32'h0BADF00D);
      chk("w0_rd_err", 32'(err0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
